// File: rtl/plic_pkg.sv
// Shared PLIC constants: default geometry, target-arbiter state encoding and the
// reserved "no interrupt" claim ID.
package plic_pkg;

  localparam int NUM_SRC_D    = 31;
  localparam int PRIO_W_D     = 3;
  localparam int ID_W_D       = 5;
  localparam int SETTLE_CYC_D = 2;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RESP   = 2'b01;
  localparam logic [1:0] ST_SETTLE = 2'b10;

  localparam int ID_NONE = 0;

endpackage

// File: rtl/plic_max_sel.sv
// Combinational max-priority selector over a candidate vector; ties resolve to the
// lower source ID, no candidate yields ID 0 / priority 0.
module plic_max_sel
  import plic_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int PRIO_W  = PRIO_W_D,
  parameter int ID_W    = ID_W_D
) (
  input  logic [NUM_SRC-1:0]        cand,
  input  logic [NUM_SRC*PRIO_W-1:0] prio,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio
);

  localparam int LVLS   = $clog2(NUM_SRC);
  localparam int LEAVES = 1 << LVLS;

  logic [LEAVES-1:0]        cand_pad;
  logic [LEAVES*PRIO_W-1:0] prio_pad;
  logic [ID_W-1:0]          t_id [LEAVES];
  logic [PRIO_W-1:0]        t_pr [LEAVES];

  assign cand_pad = LEAVES'(cand);
  assign prio_pad = (LEAVES*PRIO_W)'(prio);

  // Reduce pairwise in place; node n of a level reads 2n/2n+1, so the left
  // (lower-ID) half keeps the tie.
  always_comb begin
    for (int n = 0; n < LEAVES; n++) begin
      t_id[n] = cand_pad[n] ? ID_W'(n + 1) : '0;
      t_pr[n] = cand_pad[n] ? prio_pad[n*PRIO_W +: PRIO_W] : '0;
    end
    for (int l = 1; l <= LVLS; l++) begin
      for (int n = 0; n < (LEAVES >> l); n++) begin
        if (t_pr[2*n+1] > t_pr[2*n]) begin
          t_id[n] = t_id[2*n+1];
          t_pr[n] = t_pr[2*n+1];
        end else begin
          t_id[n] = t_id[2*n];
          t_pr[n] = t_pr[2*n];
        end
      end
    end
  end

  assign win_id   = t_id[0];
  assign win_prio = t_pr[0];

endmodule

// File: rtl/plic_target_arbiter.sv
// Per-target PLIC stage: picks the best enabled pending source, drives eip and
// services claim reads with a short blanking window while the IP FSM drops.
module plic_target_arbiter
  import plic_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_D,
  parameter int PRIO_W     = PRIO_W_D,
  parameter int ID_W       = ID_W_D,
  parameter int SETTLE_CYC = SETTLE_CYC_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        ip,
  input  logic [NUM_SRC-1:0]        ie,
  input  logic [NUM_SRC*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic                      claim_req,
  output logic                      claim_valid,
  output logic [ID_W-1:0]           claim_id,
  output logic [NUM_SRC-1:0]        claim,
  output logic                      claim_busy,
  output logic                      eip
);

  localparam int CNT_W = $clog2(SETTLE_CYC);

  logic [1:0]         state_q;
  logic [ID_W-1:0]    cid_q, best_id_q, win_id;
  logic [PRIO_W-1:0]  best_prio_q, win_prio;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_SRC-1:0] cand;

  assign claim_busy  = (state_q != ST_IDLE);
  assign claim_valid = (state_q == ST_RESP);
  assign claim_id    = claim_valid ? cid_q : ID_W'(ID_NONE);

  // The claimed source stays masked until IDLE so a slow-dropping ip is not re-picked.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic masked;
    assign masked   = claim_busy && (cid_q == ID_W'(g + 1));
    assign cand[g]  = ip[g] && ie[g] && (|prio[g*PRIO_W +: PRIO_W]) && !masked;
    assign claim[g] = claim_valid && (cid_q == ID_W'(g + 1));
  end

  plic_max_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_sel (
    .cand     (cand),
    .prio     (prio),
    .win_id   (win_id),
    .win_prio (win_prio)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      cid_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      cnt_q       <= '0;
      eip         <= 1'b0;
    end else begin
      best_id_q   <= win_id;
      best_prio_q <= win_prio;
      eip         <= (state_q == ST_IDLE) && (best_prio_q > threshold);
      case (state_q)
        ST_IDLE: begin
          if (claim_req) begin
            state_q <= ST_RESP;
            cid_q   <= best_id_q;
          end
        end
        ST_RESP: begin
          cnt_q   <= CNT_W'(SETTLE_CYC - 1);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Scoreboard bench for plic_target_arbiter: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the claim/eip rules.
module tb_plic_target_arbiter;

  localparam int NUM_SRC    = 31;
  localparam int PRIO_W     = 3;
  localparam int ID_W       = 5;
  localparam int SETTLE_CYC = 2;
  localparam int RESP_LEFT  = SETTLE_CYC + 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_SRC-1:0]        ip = '0;
  logic [NUM_SRC-1:0]        ie = '0;
  logic [NUM_SRC*PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]         threshold = '0;
  logic                      claim_req = 1'b0;
  logic                      claim_valid;
  logic [ID_W-1:0]           claim_id;
  logic [NUM_SRC-1:0]        claim;
  logic                      claim_busy;
  logic                      eip;

  logic [PRIO_W-1:0] pr [1:NUM_SRC];

  int tests = 0;
  int fails = 0;

  plic_target_arbiter #(
    .NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ip(ip), .ie(ie), .prio(prio), .threshold(threshold),
    .claim_req(claim_req), .claim_valid(claim_valid), .claim_id(claim_id),
    .claim(claim), .claim_busy(claim_busy), .eip(eip)
  );

  always #5 clk = ~clk;

  always_comb begin
    prio = '0;
    for (int s = 1; s <= NUM_SRC; s++) prio[(s-1)*PRIO_W +: PRIO_W] = pr[s];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_SRC-1:0] onehot(input int id);
    onehot = '0;
    if (id != 0) onehot[id-1] = 1'b1;
  endfunction

  // Highest priority among candidates, then the lowest ID holding that priority.
  function automatic void ref_winner(input int mask, output int wid, output int wp);
    int c[$];
    wid = 0;
    wp  = 0;
    for (int s = 1; s <= NUM_SRC; s++)
      if (ip[s-1] && ie[s-1] && pr[s] != 0 && s != mask) c.push_back(s);
    foreach (c[k]) if (int'(pr[c[k]]) > wp) wp = int'(pr[c[k]]);
    foreach (c[k]) if (wid == 0 && int'(pr[c[k]]) == wp) wid = c[k];
  endfunction

  // Reference model: m_busy counts the cycles left before the target is idle again.
  int m_best_id = 0, m_best_prio = 0, m_busy = 0, m_cid = 0;
  bit m_eip = 1'b0;
  int exp_q[$];

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_best_id   <= 0;
      m_best_prio <= 0;
      m_busy      <= 0;
      m_cid       <= 0;
      m_eip       <= 1'b0;
      exp_q.delete();
    end else begin : mdl
      int wid, wp;
      ref_winner((m_busy == 0) ? 0 : m_cid, wid, wp);
      m_best_id   <= wid;
      m_best_prio <= wp;
      m_eip       <= (m_busy == 0) && (m_best_prio > int'(threshold));
      if (m_busy == 0) begin
        if (claim_req) begin
          exp_q.push_back(m_best_id);
          m_cid  <= m_best_id;
          m_busy <= RESP_LEFT;
        end
      end else begin
        m_busy <= m_busy - 1;
      end
    end
  end

  always @(negedge clk) begin : mon
    int e;
    chk("eip", eip, m_eip);
    chk("claim_busy", claim_busy, m_busy != 0);
    chk("claim_valid", claim_valid, m_busy == RESP_LEFT);
    if (claim_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: claim_valid with id %0d but no claim expected", claim_id);
      end else begin
        e = exp_q.pop_front();
        chk("claim_id", claim_id, e);
        chk("claim_onehot", claim, onehot(e));
      end
    end else begin
      chk("claim_id_idle", claim_id, 0);
      chk("claim_idle", claim, 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_claim();
    claim_req = 1'b1;
    cyc(1);
    claim_req = 1'b0;
  endtask

  task automatic clear_all();
    ip = '0;
    for (int s = 1; s <= NUM_SRC; s++) pr[s] = '0;
    cyc(3);
  endtask

  initial begin
    for (int s = 1; s <= NUM_SRC; s++) pr[s] = '0;
    #3;
    chk("rst_eip", eip, 0);
    chk("rst_valid", claim_valid, 0);
    chk("rst_busy", claim_busy, 0);
    #9 rst_n = 1'b0;
    cyc(3);

    // 1: nothing pending, claim returns ID 0 with no pulse
    chk("t1_eip", eip, 0);
    pulse_claim();
    chk("t1_valid", claim_valid, 1);
    chk("t1_id", claim_id, 0);
    chk("t1_claim", claim, 0);
    cyc(4);

    // 2: equal priorities, lowest ID wins; eip 2 cycles after ip
    ie = '1;
    pr[3] = 3'd2;
    pr[5] = 3'd2;
    threshold = 3'd1;
    ip[2] = 1'b1;
    ip[4] = 1'b1;
    cyc(1);
    chk("t2_eip_lat1", eip, 0);
    cyc(1);
    chk("t2_eip_lat2", eip, 1);
    pulse_claim();
    chk("t2_id", claim_id, 3);
    chk("t2_claim", claim, 31'h4);
    ip &= ~claim;
    cyc(1);
    chk("t2_settle1_eip", eip, 0);
    cyc(1);
    chk("t2_settle2_eip", eip, 0);
    cyc(3);
    pulse_claim();
    chk("t2_second_id", claim_id, 5);
    ip &= ~claim;
    cyc(4);
    clear_all();

    // 3: priority equal to threshold never interrupts but is still claimable
    pr[7] = 3'd4;
    threshold = 3'd4;
    ip[6] = 1'b1;
    cyc(3);
    chk("t3_eip", eip, 0);
    pulse_claim();
    chk("t3_id", claim_id, 7);
    chk("t3_claim", claim, 31'h40);
    ip &= ~claim;
    cyc(4);
    clear_all();

    // 4: higher source rising with claim_req loses to the registered winner
    threshold = 3'd0;
    pr[2] = 3'd1;
    pr[9] = 3'd6;
    ip[1] = 1'b1;
    cyc(3);
    chk("t4_eip", eip, 1);
    ip[8] = 1'b1;
    pulse_claim();
    chk("t4_id", claim_id, 2);
    ip &= ~claim;
    cyc(4);
    chk("t4_eip_after", eip, 1);

    // 5: ip held after claim; claim_req in SETTLE ignored; source reselected later
    pulse_claim();
    chk("t5_id", claim_id, 9);
    cyc(1);
    claim_req = 1'b1;
    cyc(1);
    claim_req = 1'b0;
    chk("t5_busy", claim_busy, 1);
    chk("t5_no_valid", claim_valid, 0);
    cyc(3);
    chk("t5_eip_back", eip, 1);
    pulse_claim();
    chk("t5_reselect_id", claim_id, 9);
    cyc(4);

    // 6: reset during RESP drops outputs at once
    pulse_claim();
    chk("t6_valid", claim_valid, 1);
    chk("t6_eip", eip, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_rst_valid", claim_valid, 0);
    chk("t6_rst_claim", claim, 0);
    chk("t6_rst_eip", eip, 0);
    chk("t6_rst_busy", claim_busy, 0);
    chk("t6_rst_best", dut.best_id_q, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_post_busy", claim_busy, 0);
    ip = '0;
    cyc(4);

    // Random traffic; the IP FSM drops a claimed bit most of the time.
    for (int s = 1; s <= NUM_SRC; s++) pr[s] = PRIO_W'($urandom_range(7));
    ie = NUM_SRC'($urandom);
    for (int i = 0; i < 2000; i++) begin
      int k;
      cyc(1);
      if (|claim && $urandom_range(3) != 0) ip &= ~claim;
      claim_req = ($urandom_range(4) == 0);
      if ($urandom_range(2) == 0) begin
        k = $urandom_range(NUM_SRC - 1);
        ip[k] = ~ip[k];
      end
      if ($urandom_range(15) == 0) begin
        k = $urandom_range(NUM_SRC - 1);
        ie[k] = ~ie[k];
      end
      if ($urandom_range(15) == 0) pr[$urandom_range(NUM_SRC, 1)] = PRIO_W'($urandom_range(7));
      if ($urandom_range(63) == 0) threshold = PRIO_W'($urandom_range(7));
    end
    claim_req = 1'b0;
    cyc(6);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plic_target_arbiter.md
Name: plic_target_arbiter

Overview:
- Per-target stage directly downstream of the per-source interrupt-pending FSMs.
- Consumes the IP vector and selects the highest-priority enabled pending source. Drives the hart's external interrupt line (eip).
- Services claim reads: returns the winning source ID and pulses that source's `claim` input on its IP FSM, which clears its pending bit.
- One instance per target (hart context).

Parameters:
- NUM_SRC, 31, number of interrupt sources. Source IDs run 1..NUM_SRC; ID 0 means "no interrupt".
- PRIO_W, 3, priority width. Priority 0 means "never interrupt".
- ID_W, 5, claim ID width. Must satisfy 2^ID_W > NUM_SRC.
- SETTLE_CYC, 2, post-claim blanking cycles. Covers the IP FSM drop plus the arbitration register; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- ip  in  NUM_SRC  pending bits from the IP FSMs; bit i-1 is source i
- ie  in  NUM_SRC  per-source enable for this target
- prio  in  NUM_SRC*PRIO_W  flattened priorities; slice [i*PRIO_W +: PRIO_W] belongs to source i+1
- threshold  in  PRIO_W  target priority threshold
- claim_req  in  1  one-cycle pulse from the bus: claim register read
- claim_valid  out  1  one-cycle pulse; claim_id is valid
- claim_id  out  ID_W  claimed source ID, or 0
- claim  out  NUM_SRC  one-hot, one-cycle pulse to the claimed source's IP FSM
- claim_busy  out  1  high while not IDLE
- eip  out  1  external interrupt to the hart

Behaviour:
- Reset: every output is 0. Internal state:
  - FSM = IDLE
  - best_id_q = 0
  - best_prio_q = 0
  - settle counter = 0
- Candidate rule: source i is a candidate when ip[i-1] & ie[i-1] & (prio_i != 0) & ~(masked_i).
- Winner: the candidate with the highest priority. Ties go to the lowest ID. With no candidates, the winner is ID 0 with priority 0.
- Registration: the winner is registered every cycle into best_id_q and best_prio_q. Latency from ip change to best_* change is 1 cycle.
- eip: registered. eip <= (state==IDLE) & (best_prio_q > threshold). An ip rise reaches eip in 2 cycles. A priority equal to threshold does not interrupt.
- Masking: masked_i is high only for the claimed source while in RESP or SETTLE. This prevents re-selecting a source whose ip has not yet fallen.
- FSM states: IDLE, RESP, SETTLE.
  - IDLE & claim_req -> RESP. Capture cid = best_id_q, regardless of threshold and of eip.
  - RESP (exactly 1 cycle):
    - claim_valid = 1, claim_id = cid.
    - claim[cid-1] = 1 if cid != 0; claim is all-zero if cid == 0.
    - Load the settle counter with SETTLE_CYC-1. Next state SETTLE.
  - SETTLE: decrement the counter each cycle. Go to IDLE when the counter is 0. eip is forced 0 throughout.
  - claim_req while not IDLE: ignored. No claim_valid is produced; the bus layer is expected to check claim_busy.
- Outputs outside RESP: claim_id and claim_valid are 0. claim_id is not held after RESP.
- Simultaneous events:
  - claim_req in the same cycle as a new higher-priority ip rise: the already-registered best_id_q is returned; the new source wins later.
  - ie or prio changes mid-claim: no effect on the captured cid.
- Stale winner: if the captured source's ip dropped between selection and claim_req, the registered ID is still returned and claim is pulsed. The IP FSM ignores a claim it is not pending on.
- Reset mid-operation: immediate return to IDLE, and every output goes to 0 in that cycle (asynchronous). Any in-flight claim pulse is lost.

Decomposition:
- plic_pkg holds:
  - NUM_SRC, PRIO_W, ID_W defaults
  - state encoding (IDLE=2'b00, RESP=2'b01, SETTLE=2'b10)
  - the ID 0 "none" constant
- Sub-module plic_max_sel: a combinational priority/ID comparison tree. Inputs are the candidate vector and prio; outputs are the winning ID and priority, with ties resolved to the lower ID. Reused later by multi-target instances.

Test Plan:
1. Reset, then ip=0 -> eip=0, claim_id=0. A claim_req yields claim_valid with claim_id=0 and claim all-zero.
2. Src 3 prio 2 and src 5 prio 2, both pending and enabled, threshold 1 -> eip high 2 cycles after ip. claim_req -> claim_id=3, claim=0x4, then eip low for SETTLE_CYC cycles.
3. Src 7 prio 4 pending, threshold 4 -> eip stays 0. claim_req still returns 7 and pulses claim[6].
4. Src 2 prio 1 pending, then src 9 prio 6 rises in the same cycle as claim_req -> returns 2. After settle, eip rises and the next claim returns 9.
5. Second claim_req during SETTLE -> no claim_valid, claim_busy=1. ip held high after the claim (IP FSM not dropping) -> source masked until IDLE, then reselected.
6. rst_n asserted during RESP -> claim, claim_valid and eip drop in the same cycle. After release, state is IDLE with best_id_q=0.
